// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl: mic power-up / decimator warm-up sequencer with config latch and PCM output FIFO.
// Optional macro PDM_CAPTURE_DROP_CNT_EN adds a saturating drop_count output.
module pdm_capture_ctrl #(
    parameter int SETTLE_CYCLES   = 4096,
    parameter int DISCARD_SAMPLES = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  cfg_alpha,
    input  logic [2:0]  cfg_shift,
    output logic        mic_en,
    output logic        dec_rst,
    output logic [7:0]  dec_alpha,
    output logic [2:0]  dec_shift,
    input  logic [15:0] dec_pcm,
    input  logic        dec_valid,
    output logic [15:0] pcm_data,
    output logic        pcm_valid,
    input  logic        pcm_ready,
    output logic        busy,
    output logic        overflow
`ifdef PDM_CAPTURE_DROP_CNT_EN
    ,
    output logic [15:0] drop_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = DISCARD_SAMPLES > 1 ? $clog2(DISCARD_SAMPLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, WARMUP, RUN} state_t;

    state_t          r_state, w_next;
    logic [SW-1:0]   r_scnt;
    logic [DW-1:0]   r_dcnt;
    logic [PW-1:0]   r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [15:0]     w_head;
    logic            w_start_ok, w_settle_done, w_mic_en, w_dec_rst;
    logic            w_push, w_pop, w_full, w_wr, w_drop;

    assign w_start_ok    = (r_state == IDLE) && start;
    assign w_settle_done = (SETTLE_CYCLES <= 1) || (r_scnt == SW'(SETTLE_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? SETTLE : IDLE;
            SETTLE:  w_next = stop ? IDLE : w_settle_done ? (DISCARD_SAMPLES == 0 ? RUN : WARMUP) : SETTLE;
            WARMUP:  w_next = stop ? IDLE : (dec_valid && r_dcnt == DW'(DISCARD_SAMPLES - 1)) ? RUN : WARMUP;
            RUN:     w_next = stop ? IDLE : RUN;
            default: w_next = IDLE;
        endcase
        w_mic_en  = w_next != IDLE;
        w_dec_rst = (w_next == IDLE) || (w_next == SETTLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_scnt    <= '0;
            r_dcnt    <= '0;
            mic_en    <= 1'b0;
            dec_rst   <= 1'b1;
            busy      <= 1'b0;
            dec_alpha <= 8'd255;
            dec_shift <= 3'd0;
        end else begin
            r_state <= w_next;
            mic_en  <= w_mic_en;
            dec_rst <= w_dec_rst;
            busy    <= w_mic_en;
            r_scnt  <= w_start_ok ? '0 : (r_state == SETTLE) ? r_scnt + SW'(1) : r_scnt;
            r_dcnt  <= w_start_ok ? '0 : (r_state == WARMUP && dec_valid) ? r_dcnt + DW'(1) : r_dcnt;
            if (w_start_ok) begin
                dec_alpha <= cfg_alpha;
                dec_shift <= cfg_shift;
            end
        end
    end

    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_push     = (r_state == RUN) && dec_valid;
    assign w_pop      = pcm_valid && pcm_ready;
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr       = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_wptr_nxt = r_wptr + (w_wr ? PW'(1) : PW'(0));
    assign w_rptr_nxt = r_rptr + (w_pop ? PW'(1) : PW'(0));
    assign w_head     = (w_wr && w_rptr_nxt == r_wptr) ? dec_pcm : r_mem[w_rptr_nxt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= dec_pcm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            pcm_valid <= 1'b0;
            pcm_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            r_wptr    <= w_wptr_nxt;
            r_rptr    <= w_rptr_nxt;
            pcm_valid <= w_wptr_nxt != w_rptr_nxt;
            pcm_data  <= w_head;
            overflow  <= w_start_ok ? 1'b0 : (overflow | w_drop);
        end
    end

`ifdef PDM_CAPTURE_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_count <= '0;
        else        drop_count <= w_start_ok ? '0 : (w_drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
    end
`endif
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb_pdm_capture_ctrl: scoreboard bench for pdm_capture_ctrl (SETTLE=16, DISCARD=4, DEPTH=8).
module tb_pdm_capture_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0]  cfg_alpha = '0;
    logic [2:0]  cfg_shift = '0;
    logic [15:0] dec_pcm = '0;
    logic        dec_valid = 1'b0, pcm_ready = 1'b0;
    logic        mic_en, dec_rst, pcm_valid, busy, overflow;
    logic [7:0]  dec_alpha;
    logic [2:0]  dec_shift;
    logic [15:0] pcm_data;
`ifdef PDM_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif
    int checks = 0, failures = 0;
    logic [15:0] q[$];

    pdm_capture_ctrl #(.SETTLE_CYCLES(16), .DISCARD_SAMPLES(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_alpha(cfg_alpha), .cfg_shift(cfg_shift),
        .mic_en(mic_en), .dec_rst(dec_rst), .dec_alpha(dec_alpha), .dec_shift(dec_shift),
        .dec_pcm(dec_pcm), .dec_valid(dec_valid),
        .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
        .busy(busy), .overflow(overflow)
`ifdef PDM_CAPTURE_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && pcm_valid && pcm_ready) begin
            if (q.size() == 0) chk("pcm_unexpected", {16'h0, pcm_data}, 32'hDEAD_BEEF);
            else chk("pcm_data", {16'h0, pcm_data}, {16'h0, q.pop_front()});
        end
    end

    task automatic send(input logic [15:0] v, input bit store);
        dec_pcm = v;
        dec_valid = 1'b1;
        if (store) q.push_back(v);
        @(posedge clk); #1;
        dec_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        pcm_ready = 1'b1;
        while (q.size() != 0 && n < 60) begin
            @(posedge clk); n++;
        end
        #1;
        chk(name, q.size(), 0);
        chk({name, "_empty"}, pcm_valid, 0);
    endtask

    task automatic wait_dec_rst_low(output int n);
        n = 0;
        while (dec_rst && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    initial begin
        int n;
        #22;
        chk("rst_mic_en", mic_en, 0);
        chk("rst_dec_rst", dec_rst, 1);
        chk("rst_dec_alpha", dec_alpha, 255);
        chk("rst_dec_shift", dec_shift, 0);
        chk("rst_pcm_valid", pcm_valid, 0);
        chk("rst_pcm_data", pcm_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        // Start and settle timing
        cfg_alpha = 200; cfg_shift = 3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_mic_en", mic_en, 1);
        chk("start_dec_alpha", dec_alpha, 200);
        chk("start_dec_shift", dec_shift, 3);
        chk("start_dec_rst", dec_rst, 1);
        cfg_alpha = 77;
        wait_dec_rst_low(n);
        chk("settle_edges", n + 1, 17);
        chk("settle_alpha_held", dec_alpha, 200);
        // Warm-up discard then RUN
        pcm_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(16'(i), i > 4);
            if (i == 5) begin
                chk("first_valid", pcm_valid, 1);
                chk("first_data", pcm_data, 5);
            end
            @(posedge clk); #1;
        end
        drain("drain_warmup");
        // Fill to full, then push with a simultaneous pop, then overflow
        pcm_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(100 + i), 1'b1);
        chk("full_head", pcm_data, 100);
        chk("full_no_ovf", overflow, 0);
        pcm_ready = 1'b1;
        send(16'd200, 1'b1);
        pcm_ready = 1'b0;
        chk("pushpop_no_ovf", overflow, 0);
        chk("pushpop_head", pcm_data, 101);
        send(16'd201, 1'b0);
        send(16'd202, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_head_stable", pcm_data, 101);
        chk("ovf_valid", pcm_valid, 1);
`ifdef PDM_CAPTURE_DROP_CNT_EN
        chk("drop_count", drop_count, 2);
`endif
        drain("drain_full");
        // Start ignored while busy, stop with coincident sample
        pcm_ready = 1'b0;
        cfg_alpha = 10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_start_alpha", dec_alpha, 200);
        chk("busy_start_ovf", overflow, 1);
        send(16'd300, 1'b1);
        send(16'd301, 1'b1);
        stop = 1'b1;
        send(16'hF302, 1'b1);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_mic_en", mic_en, 0);
        chk("stop_dec_rst", dec_rst, 1);
        chk("stop_head", pcm_data, 300);
        send(16'd999, 1'b0);
        drain("drain_idle");
        // start and stop together in IDLE: start wins
        cfg_alpha = 50; cfg_shift = 5; start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_alpha", dec_alpha, 50);
        chk("restart_shift", dec_shift, 5);
        chk("restart_ovf_clr", overflow, 0);
`ifdef PDM_CAPTURE_DROP_CNT_EN
        chk("restart_drop_clr", drop_count, 0);
`endif
        wait_dec_rst_low(n);
        chk("warmup_reached", dec_rst, 0);
        send(16'd7, 1'b0);
        // Asynchronous reset mid-warmup
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_mic_en", mic_en, 0);
        chk("arst_dec_rst", dec_rst, 1);
        chk("arst_dec_alpha", dec_alpha, 255);
        chk("arst_dec_shift", dec_shift, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pcm_valid", pcm_valid, 0);
        #17 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pdm_capture_ctrl.md
# pdm_capture_ctrl

Sequencer and output buffer for the CIC3 PDM decimator. It powers up the microphone, holds the decimator in reset through the mic settle time, and discards the decimator's warm-up samples. It also freezes the HPF/scale configuration for the whole capture and buffers PCM samples in a small FIFO with a valid/ready output toward the audio sink. It sits between the register/control interface and the decimator instance, and runs in the PDM clock domain.

## Interface
- `SETTLE_CYCLES`, default 4096: PDM clocks the decimator is held in reset after mic enable.
- `DISCARD_SAMPLES`, default 4: decimator output samples dropped after reset release.
- `FIFO_DEPTH`, default 8: PCM FIFO entries; power of two, 2..64.
- `clk  in  1`: PDM clock, same clock as the decimator.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse; begins a capture from IDLE.
- `stop  in  1`: one-cycle pulse; ends the capture from any non-IDLE state.
- `cfg_alpha  in  8`: requested HPF coefficient.
- `cfg_shift  in  3`: requested output right-shift.
- `mic_en  out  1`: microphone enable/select.
- `dec_rst  out  1`: active-high synchronous reset to the decimator.
- `dec_alpha  out  8`: latched HPF coefficient to the decimator.
- `dec_shift  out  3`: latched shift to the decimator.
- `dec_pcm  in  16`: decimator PCM sample (signed).
- `dec_valid  in  1`: decimator sample strobe.
- `pcm_data  out  16`: FIFO head sample.
- `pcm_valid  out  1`: FIFO not empty.
- `pcm_ready  in  1`: sink accepts the head when high together with `pcm_valid`.
- `busy  out  1`: state is not IDLE.
- `overflow  out  1`: sticky flag; a RUN sample was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, SETTLE, WARMUP, RUN.
- IDLE: `mic_en`=0, `dec_rst`=1. A `start` pulse latches `cfg_alpha`/`cfg_shift` into `dec_alpha`/`dec_shift`, clears `overflow` and the counters, and moves to SETTLE. The FIFO is not flushed.
- SETTLE: `mic_en`=1, `dec_rst`=1. Counts `SETTLE_CYCLES` clocks, then moves to WARMUP.
- WARMUP: `dec_rst`=0. Counts `dec_valid` pulses and drops them. After the `DISCARD_SAMPLES`-th pulse, moves to RUN. If `DISCARD_SAMPLES`=0, skips directly to RUN.
- RUN: each `dec_valid` pushes `dec_pcm` into the FIFO.
- `stop` in SETTLE, WARMUP or RUN moves to IDLE on the next edge; `mic_en` drops and `dec_rst` rises in the same cycle. A `dec_valid` coinciding with `stop` in RUN is still pushed. FIFO contents remain drainable in IDLE.
- `start` outside IDLE is ignored. `start` and `stop` together in IDLE: `start` wins.
- `dec_alpha`/`dec_shift` only change on an accepted `start`. `cfg_*` changes at any other time have no effect.
- FIFO:
  - Pop when `pcm_valid && pcm_ready`.
  - Push when full with a simultaneous pop: accepted, occupancy unchanged.
  - Push when full without a pop: sample dropped, `overflow` set. It stays set until the next accepted `start` or reset.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap modulo 2×depth. Full means MSBs differ and LSBs are equal.
  - Samples pass through unmodified, full 16 bits, no arithmetic.
- Reset values: state IDLE, `mic_en`=0, `dec_rst`=1, `dec_alpha`=8'd255 (HPF bypass), `dec_shift`=0, FIFO empty, `pcm_valid`=0, `pcm_data`=0, `busy`=0, `overflow`=0.
- Reset mid-capture: all of the above apply immediately (asynchronous) and the FIFO contents are lost.

## Timing
- `start` at edge N: at N+1, `busy`=1, `mic_en`=1, and the `dec_*` config is valid.
- `dec_rst` falls at N+1+`SETTLE_CYCLES`.
- `dec_valid` at edge M in RUN: at M+1, `pcm_valid`=1 (if the FIFO was empty) and `pcm_data`=sample. Write-to-read latency is 1 cycle; no combinational path from `dec_valid` to `pcm_valid`.
- `pcm_data` is stable while `pcm_valid`=1 and `pcm_ready`=0.
- Full-rate push and pop sustained with no bubbles.
- All outputs are registered.

## Configuration
- `PDM_CAPTURE_DROP_CNT_EN` defined:
  - Adds output port `drop_count  out  16`: saturating count of dropped RUN samples.
  - Resets to 0; cleared with `overflow` on an accepted `start`; saturates at 16'hFFFF.
- Undefined: the port and counter are absent; `overflow` still operates.

## Test plan
- Reset, then `start` with `cfg_alpha`=200, `cfg_shift`=3, `SETTLE_CYCLES`=16 → `mic_en` high at +1, `dec_alpha`=200, `dec_shift`=3, `dec_rst` low exactly 17 cycles after `start`.
- `DISCARD_SAMPLES`=4, `dec_valid` with values 1..10 → first 4 dropped; FIFO outputs 5,6,...,10 in order.
- `pcm_ready`=0, `FIFO_DEPTH`=8, 10 RUN samples → `pcm_valid`=1 with `pcm_data` = first sample; 8 stored, 2 dropped, `overflow`=1 (and `drop_count`=2 when the macro is defined).
- FIFO full, `dec_valid` and pop in the same cycle → no drop, `overflow` stays 0, occupancy stays 8.
- `stop` during RUN with 3 queued samples → IDLE next cycle, `mic_en`=0, `dec_rst`=1, 3 samples still drain; `cfg_alpha` changed to 10 while busy → `dec_alpha` unchanged.
- `rst_n` low mid-WARMUP, asynchronous to `clk` → all outputs at reset values before the next edge, `dec_alpha`=255.
